// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//
// Stall/flush controller for the 5-stage pipeline. It covers the hazards that
// operand forwarding in EX cannot resolve:
//   - load-use: the instruction in ID needs the result of a load still in EX.
//     One bubble is inserted, and the load data is then forwarded from MEM.
//   - memory wait: the MEM stage is blocked on dmem, so the whole front of
//     the pipeline is frozen.
//   - taken branch/jump resolved in EX: the younger instructions in IF/ID and
//     ID are squashed.
// It also keeps saturating performance counters and a sticky dmem-timeout flag.
//
// Parameters
//   CNT_W        width of the stall_cycles / flush_count counters
//   MEM_TIMEOUT  number of consecutive dmem-wait cycles that raise mem_timeout
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   ID_rs1, ID_rs2      source registers of the instruction in ID
//   ID_ValidReg[2:0]    [0] rd written, [1] rs1 read, [2] rs2 read
//   EX_rd, EX_ValidReg  destination register and valid bits of the EX instr
//   EX_is_load          the EX instruction is a load
//   EX_branch_taken     the EX instruction redirects the PC this cycle
//   MEM_req, MEM_ready  dmem access active / completing this cycle
//   PC_stall .. MEM_WB_bubble  per-stage hold / squash / NOP-insert controls
//                       (combinational from state and inputs)
//   mem_timeout         sticky flag: dmem wait reached MEM_TIMEOUT cycles
//   stall_cycles        saturating count of cycles with PC_stall=1
//   flush_count         saturating count of branch flushes
// ---------------------------------------------------------------------------
module hazard_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [2:0]       ID_ValidReg,
    input  logic [4:0]       EX_rd,
    input  logic [2:0]       EX_ValidReg,
    input  logic             EX_is_load,
    input  logic             EX_branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // The wait counter only needs to reach MEM_TIMEOUT; it saturates there.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               w_mem_wait;
    logic               w_rs1_hit;
    logic               w_rs2_hit;
    logic               w_load_use;

    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_flush_count;

    // Saturating increment: a counter parked at all-ones never wraps to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Hazard detection terms.
    assign w_mem_wait = MEM_req & ~MEM_ready;
    assign w_rs1_hit  = ID_ValidReg[1] & (ID_rs1 == EX_rd);
    assign w_rs2_hit  = ID_ValidReg[2] & (ID_rs2 == EX_rd);
    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign w_load_use = EX_is_load & EX_ValidReg[0] & (EX_rd != 5'd0) &
                        (w_rs1_hit | w_rs2_hit);

    // Next-state and control-output decode in fixed priority order.
    always_comb begin
        w_next_state  = ST_RUN;
        PC_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_stall   = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_stall  = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (rst) begin
            // Reset forces every control low without waiting for an edge.
            w_next_state = ST_RUN;
        end else if (w_mem_wait) begin
            // Freeze everything up to EX/MEM; branch and load-use are simply
            // re-evaluated once the access completes because EX is frozen.
            PC_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_stall  = 1'b1;
            MEM_WB_bubble = 1'b1;
            w_next_state  = ST_MEM_WAIT;
        end else if (EX_branch_taken) begin
            // A taken branch squashes the dependent instruction anyway, so it
            // wins over any load-use hazard seen in the same cycle.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            w_next_state = ST_RUN;
        end else if (w_load_use && (r_state != ST_LOAD_USE)) begin
            // One bubble is enough: afterwards the load sits in MEM and its
            // data reaches the consumer through the forwarding network.
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
            w_next_state = ST_LOAD_USE;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (w_next_state)
                ST_RUN:      r_state <= ST_RUN;
                ST_LOAD_USE: r_state <= ST_LOAD_USE;
                ST_MEM_WAIT: r_state <= ST_MEM_WAIT;
                default:     r_state <= ST_RUN;
            endcase
        end
    end

    // Consecutive dmem-wait counter and the sticky timeout flag it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= {WAIT_W{1'b0}};
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_mem_wait) begin
                if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end else begin
                    r_wait_cnt <= r_wait_cnt;
                end
            end else begin
                r_wait_cnt <= {WAIT_W{1'b0}};
            end
            // Raised on the edge that closes the MEM_TIMEOUT-th wait cycle;
            // only reset clears it.
            if (w_mem_wait && (r_wait_cnt == WAIT_LAST)) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_flush_count  <= {CNT_W{1'b0}};
        end else begin
            if (PC_stall) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (IF_ID_flush) begin
                r_flush_count <= sat_inc(r_flush_count);
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    localparam int CNT_W = 4;

    // Control vector order: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
    //                        ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MW   = 7'b1101011;

    logic             clk;
    logic             rst;
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic [2:0]       ID_ValidReg;
    logic [4:0]       EX_rd;
    logic [2:0]       EX_ValidReg;
    logic             EX_is_load;
    logic             EX_branch_taken;
    logic             MEM_req;
    logic             MEM_ready;
    logic             PC_stall;
    logic             IF_ID_stall;
    logic             IF_ID_flush;
    logic             ID_EX_stall;
    logic             ID_EX_bubble;
    logic             EX_MEM_stall;
    logic             MEM_WB_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    logic [6:0] w_ctrl;
    assign w_ctrl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
                     ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble};

    hazard_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_ValidReg     (ID_ValidReg),
        .EX_rd           (EX_rd),
        .EX_ValidReg     (EX_ValidReg),
        .EX_is_load      (EX_is_load),
        .EX_branch_taken (EX_branch_taken),
        .MEM_req         (MEM_req),
        .MEM_ready       (MEM_ready),
        .PC_stall        (PC_stall),
        .IF_ID_stall     (IF_ID_stall),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_stall     (ID_EX_stall),
        .ID_EX_bubble    (ID_EX_bubble),
        .EX_MEM_stall    (EX_MEM_stall),
        .MEM_WB_bubble   (MEM_WB_bubble),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       idv;
        logic [4:0]       exrd;
        logic [2:0]       exv;
        logic             ld;
        logic             br;
        logic             mreq;
        logic             mrdy;
        logic [6:0]       ctrl;   // expected controls before the edge
        logic [CNT_W-1:0] sc;     // expected stall_cycles after the edge
        logic [CNT_W-1:0] fc;     // expected flush_count after the edge
        logic             to;     // expected mem_timeout after the edge
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] idv,
                       input logic [4:0] exrd, input logic [2:0] exv, input logic ld,
                       input logic br, input logic mreq, input logic mrdy,
                       input logic [6:0] ctrl, input int sc, input int fc, input logic to);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.idv = idv; v.exrd = exrd; v.exv = exv;
        v.ld = ld; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        v.ctrl = ctrl; v.sc = CNT_W'(sc); v.fc = CNT_W'(fc); v.to = to;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] idv,
                         input logic [4:0] exrd, input logic [2:0] exv, input logic ld,
                         input logic br, input logic mreq, input logic mrdy);
        ID_rs1 = rs1; ID_rs2 = rs2; ID_ValidReg = idv;
        EX_rd = exrd; EX_ValidReg = exv; EX_is_load = ld;
        EX_branch_taken = br; MEM_req = mreq; MEM_ready = mrdy;
    endtask

    initial begin
        drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Reset state, with a hazard pattern on the inputs to prove gating.
        repeat (2) @(posedge clk);
        drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check("reset ctrl", 32'(w_ctrl), 32'(C_NONE));
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset flush_count", 32'(flush_count), 32'd0);
        check("reset mem_timeout", 32'(mem_timeout), 32'd0);
        drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //  rs1    rs2    idv     exrd   exv    ld    br    mreq  mrdy   ctrl   sc  fc  to
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   1,  0, 1'b0); // T1
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 1,  0, 1'b0); // single bubble
        add(5'd5, 5'd0, 3'b010, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 1,  0, 1'b0); // T2 rd=0
        add(5'd5, 5'd0, 3'b001, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 1,  0, 1'b0); // T2 idv
        add(5'd3, 5'd7, 3'b100, 5'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   2,  0, 1'b0); // rs2 hit
        add(5'd3, 5'd7, 3'b100, 5'd7, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2,  0, 1'b0);
        add(5'd3, 5'd7, 3'b100, 5'd7, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2,  0, 1'b0); // not load
        add(5'd3, 5'd7, 3'b100, 5'd7, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2,  0, 1'b0); // EX no rd
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   2,  1, 1'b0); // T3
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2,  1, 1'b0);
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   3,  1, 1'b0);
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   3,  2, 1'b0); // branch in LOAD_USE
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, C_MW,   4,  2, 1'b0); // T4 wait 1
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, C_MW,   5,  2, 1'b1); // wait 2
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, C_MW,   6,  2, 1'b1); // wait 3
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 6,  2, 1'b1); // ready
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, C_MW,   7,  2, 1'b1); // branch deferred
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,   7,  3, 1'b1);
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 7,  3, 1'b1); // no req
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, C_MW,   8,  3, 1'b1); // load-use deferred
        add(5'd5, 5'd0, 3'b010, 5'd5, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, C_LU,   9,  3, 1'b1);
        add(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 9,  3, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].idv, vecs[i].exrd, vecs[i].exv,
                  vecs[i].ld, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
            #2;
            check($sformatf("vec%0d ctrl", i), 32'(w_ctrl), 32'(vecs[i].ctrl));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d stall_cycles", i), 32'(stall_cycles), 32'(vecs[i].sc));
            check($sformatf("vec%0d flush_count", i), 32'(flush_count), 32'(vecs[i].fc));
            check($sformatf("vec%0d mem_timeout", i), 32'(mem_timeout), 32'(vecs[i].to));
        end

        // T5: asynchronous reset pulse between edges in the middle of a wait.
        @(negedge clk);
        drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check("T5 wait ctrl", 32'(w_ctrl), 32'(C_MW));
        @(posedge clk);
        #1;
        check("T5 wait stall_cycles", 32'(stall_cycles), 32'd10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("T5 async ctrl", 32'(w_ctrl), 32'(C_NONE));
        check("T5 async stall_cycles", 32'(stall_cycles), 32'd0);
        check("T5 async flush_count", 32'(flush_count), 32'd0);
        check("T5 async mem_timeout", 32'(mem_timeout), 32'd0);
        drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("T5 post ctrl", 32'(w_ctrl), 32'(C_NONE));
        check("T5 post stall_cycles", 32'(stall_cycles), 32'd0);
        check("T5 post mem_timeout", 32'(mem_timeout), 32'd0);
        // A load-use stall right after release shows the FSM is back in RUN.
        @(negedge clk);
        drive(5'd9, 5'd0, 3'b010, 5'd9, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("T5 load-use ctrl", 32'(w_ctrl), 32'(C_LU));
        @(posedge clk);
        #1;
        check("T5 load-use stall_cycles", 32'(stall_cycles), 32'd1);

        // T6: 20 consecutive waits saturate the 4-bit stall counter at 15.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            check($sformatf("T6 wait%0d ctrl", k), 32'(w_ctrl), 32'(C_MW));
            @(posedge clk);
            #1;
            check($sformatf("T6 wait%0d stall_cycles", k), 32'(stall_cycles),
                  (k + 2 > 15) ? 32'd15 : 32'(k + 2));
        end
        check("T6 mem_timeout", 32'(mem_timeout), 32'd1);

        // Flush counter saturation.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 3'b000, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            check($sformatf("flush%0d ctrl", k), 32'(w_ctrl), 32'(C_BR));
            @(posedge clk);
            #1;
            check($sformatf("flush%0d flush_count", k), 32'(flush_count),
                  (k + 1 > 15) ? 32'd15 : 32'(k + 1));
        end
        check("final stall_cycles", 32'(stall_cycles), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
